// File: rtl/uv_blk_copy_if.sv
// Request/response memory bus shared by the copy initiator (master) and a responder (slave).
interface uv_blk_copy_if #(
  parameter int unsigned ALEN = 32,
  parameter int unsigned DLEN = 32,
  parameter int unsigned MLEN = DLEN / 8
);
  logic            mem_req_vld;
  logic            mem_req_rdy;
  logic            mem_req_read;
  logic [ALEN-1:0] mem_req_addr;
  logic [MLEN-1:0] mem_req_mask;
  logic [DLEN-1:0] mem_req_data;
  logic            mem_rsp_vld;
  logic            mem_rsp_rdy;
  logic [1:0]      mem_rsp_excp;
  logic [DLEN-1:0] mem_rsp_data;

  modport master (
    output mem_req_vld, mem_req_read, mem_req_addr, mem_req_mask, mem_req_data, mem_rsp_rdy,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_excp, mem_rsp_data
  );

  modport slave (
    input  mem_req_vld, mem_req_read, mem_req_addr, mem_req_mask, mem_req_data, mem_rsp_rdy,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_excp, mem_rsp_data
  );
endinterface

// File: rtl/uv_blk_copy.sv
// Single-outstanding memory-copy initiator: read a word, write it, advance, repeat.
// Stops on the first response exception and latches the faulting address and code.
module uv_blk_copy #(
  parameter int unsigned ALEN  = 32,
  parameter int unsigned DLEN  = 32,
  parameter int unsigned MLEN  = DLEN / 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [ALEN-1:0]  cfg_src,
  input  logic [ALEN-1:0]  cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ALEN-1:0]  err_addr,
  output logic [1:0]       err_excp,
  uv_blk_copy_if.master    mem
);

  localparam int unsigned WBYTES = DLEN / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_RSP, S_WR_REQ, S_WR_RSP, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ALEN-1:0]  src_ptr_q, src_ptr_d;
  logic [ALEN-1:0]  dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [DLEN-1:0]  buf_q, buf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [ALEN-1:0]  err_addr_q, err_addr_d;
  logic [1:0]       err_excp_q, err_excp_d;
  logic             req_vld_q, req_vld_d;
  logic             req_read_q, req_read_d;
  logic [ALEN-1:0]  req_addr_q, req_addr_d;
  logic [MLEN-1:0]  req_mask_q, req_mask_d;
  logic [DLEN-1:0]  req_data_q, req_data_d;
  logic             rsp_rdy_q, rsp_rdy_d;

  // Next state, datapath updates, and request fields derived from the next state
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    remain_d   = remain_q;
    buf_d      = buf_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_excp_d = err_excp_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          src_ptr_d = cfg_src;
          dst_ptr_d = cfg_dst;
          remain_d  = cfg_len;
          err_d     = 1'b0;
          state_d   = (cfg_len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: if (mem.mem_req_rdy) state_d = S_RD_RSP;
      S_RD_RSP: begin
        if (mem.mem_rsp_vld) begin
          if (mem.mem_rsp_excp != 2'b00) begin
            err_d      = 1'b1;
            err_addr_d = src_ptr_q;
            err_excp_d = mem.mem_rsp_excp;
            state_d    = S_DONE;
          end else begin
            buf_d   = mem.mem_rsp_data;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: if (mem.mem_req_rdy) state_d = S_WR_RSP;
      S_WR_RSP: begin
        if (mem.mem_rsp_vld) begin
          if (mem.mem_rsp_excp != 2'b00) begin
            err_d      = 1'b1;
            err_addr_d = dst_ptr_q;
            err_excp_d = mem.mem_rsp_excp;
            state_d    = S_DONE;
          end else begin
            src_ptr_d = src_ptr_q + ALEN'(WBYTES);
            dst_ptr_d = dst_ptr_q + ALEN'(WBYTES);
            remain_d  = remain_q - LEN_W'(1);
            state_d   = (remain_q == LEN_W'(1)) ? S_DONE : S_RD_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request fields only change when a new request state is entered, so they hold while stalled
    busy_d     = state_d inside {S_RD_REQ, S_RD_RSP, S_WR_REQ, S_WR_RSP};
    done_d     = (state_d == S_DONE);
    req_vld_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    req_read_d = (state_d == S_RD_REQ);
    req_addr_d = req_addr_q;
    if (state_d == S_RD_REQ) req_addr_d = src_ptr_d;
    if (state_d == S_WR_REQ) req_addr_d = dst_ptr_d;
    req_mask_d = req_vld_d ? '1 : '0;
    req_data_d = (state_d == S_WR_REQ) ? buf_d : '0;
    rsp_rdy_d  = !req_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      remain_q   <= '0;
      buf_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_excp_q <= '0;
      req_vld_q  <= 1'b0;
      req_read_q <= 1'b0;
      req_addr_q <= '0;
      req_mask_q <= '0;
      req_data_q <= '0;
      rsp_rdy_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      remain_q   <= remain_d;
      buf_q      <= buf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_excp_q <= err_excp_d;
      req_vld_q  <= req_vld_d;
      req_read_q <= req_read_d;
      req_addr_q <= req_addr_d;
      req_mask_q <= req_mask_d;
      req_data_q <= req_data_d;
      rsp_rdy_q  <= rsp_rdy_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign err_addr         = err_addr_q;
  assign err_excp         = err_excp_q;
  assign mem.mem_req_vld  = req_vld_q;
  assign mem.mem_req_read = req_read_q;
  assign mem.mem_req_addr = req_addr_q;
  assign mem.mem_req_mask = req_mask_q;
  assign mem.mem_req_data = req_data_q;
  assign mem.mem_rsp_rdy  = rsp_rdy_q;

endmodule

// File: tb/tb_uv_blk_copy.sv
// Bench for uv_blk_copy: programmable-wait responder, transaction-level model of the
// expected request stream / done timing / error outcome, and a per-cycle compare process.
module tb_uv_blk_copy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic [31:0] err_addr;
  logic [1:0]  err_excp;

  uv_blk_copy_if #(.ALEN(32), .DLEN(32)) mem_if ();

  uv_blk_copy dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .err_excp(err_excp), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] src_word(logic [31:0] a);
    return 32'hC0DE_0000 + (a >> 2);
  endfunction

  // Responder configuration
  int          rd_stall = 0, rd_delay = 0, wr_stall = 0, wr_delay = 0;
  bit          exc_en = 0, exc_read = 0;
  logic [31:0] exc_addr = '0;
  logic [1:0]  exc_code = '0;
  bit          stray_go = 0;

  // Model state
  typedef struct packed { logic rd; logic [31:0] addr; logic [31:0] data; } req_t;
  req_t        exp_q[$];
  int          m_t = -10, m_d = -10;
  logic        m_err = 0, p_err = 0;
  logic [31:0] m_err_addr = '0, p_addr = '0;
  logic [1:0]  m_excp = '0, p_excp = '0;

  // Observations
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;
  int          start_cyc = 0, done_cyc = 0;

  // Expected outcome of a start sampled at edge t (edge closing cycle t)
  function automatic void model_start(int t, logic [31:0] s, logic [31:0] d, logic [15:0] n);
    int tt;
    logic [31:0] sa, da;
    req_t r;
    if (t <= m_d) return;
    m_t = t; exp_q.delete(); tt = 0;
    p_err = 0; p_addr = m_err_addr; p_excp = m_excp;
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      r.rd = 1'b1; r.addr = sa; r.data = '0; exp_q.push_back(r);
      tt += 2 + rd_stall + rd_delay;
      if (exc_en && exc_read && exc_addr == sa) begin
        p_err = 1; p_addr = sa; p_excp = exc_code; break;
      end
      r.rd = 1'b0; r.addr = da; r.data = src_word(sa); exp_q.push_back(r);
      tt += 2 + wr_stall + wr_delay;
      if (exc_en && !exc_read && exc_addr == da) begin
        p_err = 1; p_addr = da; p_excp = exc_code; break;
      end
    end
    m_d = t + 1 + tt;
  endfunction

  // Responder + per-cycle compare, all at the falling edge
  logic        pend = 0, armed = 0, hs_req_q = 0, hs_rsp_q = 0;
  logic        prev_vld = 0, prev_hs = 0, prev_read = 0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic        sv_rd = 0;
  logic [31:0] sv_addr = '0;
  int          pend_wait = 0, stall_left = 0;
  logic        busy_exp;
  req_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
      chk("rst_err", err, 0);             chk("rst_err_addr", err_addr, 0);
      chk("rst_err_excp", err_excp, 0);   chk("rst_vld", mem_if.mem_req_vld, 0);
      chk("rst_read", mem_if.mem_req_read, 0); chk("rst_addr", mem_if.mem_req_addr, 0);
      chk("rst_mask", mem_if.mem_req_mask, 0); chk("rst_data", mem_if.mem_req_data, 0);
      chk("rst_rsp_rdy", mem_if.mem_rsp_rdy, 1);
      m_t = -10; m_d = -10; m_err = 0; m_err_addr = '0; m_excp = '0; exp_q.delete();
      mem_if.mem_req_rdy = 0; mem_if.mem_rsp_vld = 0;
      mem_if.mem_rsp_excp = '0; mem_if.mem_rsp_data = '0;
      pend = 0; armed = 0; hs_req_q = 0; hs_rsp_q = 0; prev_vld = 0; prev_hs = 0;
    end else begin
      busy_exp = (cyc > m_t) && (cyc < m_d);
      if (cyc == m_t + 1) m_err = 0;
      if (cyc == m_d) begin
        m_err = p_err; m_err_addr = p_addr; m_excp = p_excp;
        chk("all_req_issued", 64'(exp_q.size()), 0);
      end
      chk("busy", busy, busy_exp);
      chk("done", done, cyc == m_d);
      chk("err", err, m_err);
      chk("err_addr", err_addr, m_err_addr);
      chk("err_excp", err_excp, m_excp);

      if (hs_rsp_q) begin mem_if.mem_rsp_vld = 0; pend = 0; end
      if (hs_req_q) begin
        pend = 1; armed = 0;
        pend_wait = sv_rd ? rd_delay : wr_delay;
        mem_if.mem_rsp_data = sv_rd ? src_word(sv_addr) : 32'h0;
        mem_if.mem_rsp_excp = (exc_en && exc_read == sv_rd && exc_addr == sv_addr) ? exc_code : 2'b00;
      end

      chk("rsp_rdy", mem_if.mem_rsp_rdy, !mem_if.mem_req_vld);
      if (mem_if.mem_req_vld) begin
        chk("one_outstanding", pend | mem_if.mem_rsp_vld, 0);
        chk("req_in_copy", busy_exp, 1);
        chk("req_mask", mem_if.mem_req_mask, 4'hF);
        if (mem_if.mem_req_read) chk("rd_data_zero", mem_if.mem_req_data, 0);
        if (prev_vld && !prev_hs) begin
          chk("stall_read", mem_if.mem_req_read, prev_read);
          chk("stall_addr", mem_if.mem_req_addr, prev_addr);
          chk("stall_data", mem_if.mem_req_data, prev_data);
        end
      end

      if (pend && !mem_if.mem_rsp_vld) begin
        if (pend_wait == 0) mem_if.mem_rsp_vld = 1;
        else pend_wait--;
      end else if (stray_go && !pend && !mem_if.mem_rsp_vld) begin
        stray_go = 0;
        mem_if.mem_rsp_vld = 1; mem_if.mem_rsp_data = 32'hDEAD_BEEF; mem_if.mem_rsp_excp = 2'b11;
        chk("stray_drain", mem_if.mem_rsp_rdy, 1);
      end

      mem_if.mem_req_rdy = 0;
      if (mem_if.mem_req_vld && !pend) begin
        if (!armed) begin
          stall_left = mem_if.mem_req_read ? rd_stall : wr_stall;
          armed = 1;
        end
        if (stall_left == 0) mem_if.mem_req_rdy = 1;
        else stall_left--;
      end

      hs_req_q = mem_if.mem_req_vld & mem_if.mem_req_rdy;
      hs_rsp_q = mem_if.mem_rsp_vld & mem_if.mem_rsp_rdy;
      if (hs_req_q) begin
        sv_rd = mem_if.mem_req_read; sv_addr = mem_if.mem_req_addr;
        if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("req_read", mem_if.mem_req_read, e.rd);
          chk("req_addr", mem_if.mem_req_addr, e.addr);
          if (!e.rd) chk("req_wdata", mem_if.mem_req_data, e.data);
        end
        if (!mem_if.mem_req_read) begin
          wr_cnt++; last_wr_addr = mem_if.mem_req_addr; last_wr_data = mem_if.mem_req_data;
        end
      end
      prev_vld = mem_if.mem_req_vld; prev_hs = hs_req_q; prev_read = mem_if.mem_req_read;
      prev_addr = mem_if.mem_req_addr; prev_data = mem_if.mem_req_data;
    end
  end

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_start = 1;
    start_cyc = cyc;
    model_start(cyc, s, d, n);
    @(negedge clk);
    cfg_start = 0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    chk("done_timeout", n < limit, 1);
    done_cyc = cyc;
  endtask

  task automatic resp_cfg(input int rs, input int rd, input int ws, input int wd);
    rd_stall = rs; rd_delay = rd; wr_stall = ws; wr_delay = wd;
  endtask

  initial begin
    cfg_start = 0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1;

    // Basic copy, zero-wait responder
    resp_cfg(0, 0, 0, 0); wr_cnt = 0;
    start(32'h0, 32'h2000_0000, 16'd4); wait_done(200);
    chk("basic_latency", 64'(done_cyc - start_cyc), 17);
    chk("basic_wr_cnt", 64'(wr_cnt), 4);
    chk("basic_last_addr", last_wr_addr, 32'h2000_000C);
    chk("basic_last_data", last_wr_data, 32'hC0DE_0003);
    chk("basic_err", err, 0);

    // Zero length
    start(32'h10, 32'h2000_0010, 16'd0); wait_done(20);
    chk("zero_latency", 64'(done_cyc - start_cyc), 1);

    // Read backpressure: 3 request stalls and 2 response delays per read
    resp_cfg(3, 2, 0, 0); wr_cnt = 0;
    start(32'h0, 32'h2000_0000, 16'd4); wait_done(300);
    chk("bp_rd_latency", 64'(done_cyc - start_cyc), 37);
    chk("bp_rd_wr_cnt", 64'(wr_cnt), 4);
    chk("bp_rd_last_data", last_wr_data, 32'hC0DE_0003);

    // Write backpressure
    resp_cfg(0, 0, 3, 2);
    start(32'h80, 32'h2000_0080, 16'd2); wait_done(300);
    chk("bp_wr_latency", 64'(done_cyc - start_cyc), 19);
    resp_cfg(0, 0, 0, 0);

    // Read exception on second read
    exc_en = 1; exc_read = 1; exc_addr = 32'h104; exc_code = 2'b01; wr_cnt = 0;
    start(32'h100, 32'h2000_0100, 16'd3); wait_done(200);
    chk("rdexc_latency", 64'(done_cyc - start_cyc), 7);
    chk("rdexc_err", err, 1);
    chk("rdexc_addr", err_addr, 32'h104);
    chk("rdexc_code", err_excp, 1);
    chk("rdexc_wr_cnt", 64'(wr_cnt), 1);

    // Write exception on last word; the start also clears the previous error
    exc_read = 0; exc_addr = 32'h2000_0204; exc_code = 2'b10; wr_cnt = 0;
    start(32'h200, 32'h2000_0200, 16'd2);
    chk("err_cleared", err, 0);
    wait_done(200);
    chk("wrexc_latency", 64'(done_cyc - start_cyc), 9);
    chk("wrexc_err", err, 1);
    chk("wrexc_addr", err_addr, 32'h2000_0204);
    chk("wrexc_code", err_excp, 2);
    exc_en = 0;

    // Start while busy is ignored
    wr_cnt = 0;
    start(32'h300, 32'h2000_0300, 16'd3);
    repeat (3) @(negedge clk);
    start(32'h900, 32'h3000_0000, 16'd1);
    wait_done(200);
    done_cyc = cyc;
    chk("busy_start_wr_cnt", 64'(wr_cnt), 3);
    chk("busy_start_last_addr", last_wr_addr, 32'h2000_0308);
    chk("busy_start_err", err, 0);

    // Reset while a write request is stalled, then a stray response
    resp_cfg(0, 0, 6, 0);
    start(32'h400, 32'h2000_0400, 16'd2);
    begin
      int n = 0;
      while (!(mem_if.mem_req_vld && !mem_if.mem_req_read) && n < 50) begin @(negedge clk); n++; end
      chk("reached_wr_req", n < 50, 1);
    end
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    resp_cfg(0, 0, 0, 0);
    stray_go = 1;
    repeat (4) @(negedge clk);
    chk("stray_consumed", stray_go, 0);

    // Recovery copy with wrapping addresses
    wr_cnt = 0;
    start(32'hFFFF_FFFC, 32'hFFFF_FFFC, 16'd2); wait_done(100);
    chk("wrap_latency", 64'(done_cyc - start_cyc), 9);
    chk("wrap_last_addr", last_wr_addr, 32'h0000_0000);
    chk("wrap_last_data", last_wr_data, 32'hC0DE_0000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
